// File: rtl/instr_issuer_pkg.sv
// Shared definitions for the register-file instruction issuer: opcodes, bus codes, compare codes, FSM states.
// S_PAUSE exists only when INSTR_ISSUER_STEP_EN is defined.
package instr_issuer_pkg;

    localparam logic [3:0] OP_LD   = 4'h0;
    localparam logic [3:0] OP_ST   = 4'h1;
    localparam logic [3:0] OP_MI   = 4'h2;
    localparam logic [3:0] OP_MR   = 4'h3;
    localparam logic [3:0] OP_NOP  = 4'h4;
    localparam logic [3:0] OP_CM   = 4'h7;
    localparam logic [3:0] OP_HALT = 4'hE;
    localparam logic [3:0] OP_CMI  = 4'hF;

    localparam logic [7:0] NOP_WORD = 8'h40;

    localparam logic [1:0] RW_NONE  = 2'b00;
    localparam logic [1:0] RW_READ  = 2'b10;
    localparam logic [1:0] RW_WRITE = 2'b01;

    localparam logic [7:0] CMP_EQ = 8'd0;
    localparam logic [7:0] CMP_LT = 8'd1;
    localparam logic [7:0] CMP_GT = 8'd2;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_DECODE,
        S_ISSUE,
        S_GAP,
        S_RDA,
        S_RDA_W,
        S_RDB,
        S_RDB_W,
        S_DONE
`ifdef INSTR_ISSUER_STEP_EN
        , S_PAUSE
`endif
    } state_t;

    function automatic logic is_cmp_op(input logic [3:0] op);
        return (op == OP_CM) || (op == OP_CMI);
    endfunction

    // CMI immediate: 2-bit field sign-extended to the register width.
    function automatic logic [7:0] cmi_imm(input logic [1:0] field);
        return {{6{field[1]}}, field};
    endfunction

endpackage

// File: rtl/instr_issuer_cmp.sv
// Combinational operand comparator producing the 8-bit compare code driven onto the register file input.
module issuer_cmp
    import instr_issuer_pkg::*;
(
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] code
);

    always_comb begin
        code = CMP_GT;
        if (a == b) begin
            code = CMP_EQ;
        end else if (a < b) begin
            code = CMP_LT;
        end
    end

endmodule

// File: rtl/instr_issuer.sv
// Fetches program words and issues them to the 4x8 register file; CM/CMI read operands first.
// Optional single-step mode: define INSTR_ISSUER_STEP_EN to add the `step` input and the PAUSE state.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | waiting for start
// FETCH    | prog_addr = pc presented to ROM
// WAIT     | ROM latency
// DECODE   | prog_data latched as instr; sets up bus for next strobe
// ISSUE    | reg_on pulse with word = instr, in_val = compare code or 0
// GAP      | reg_on low; advance pc or finish
// RDA      | read strobe of operand A (word = NOP)
// RDA_W    | capture A; CMI compares against immediate here
// RDB      | read strobe of operand B (CM only)
// RDB_W    | compare A with returned B
// DONE     | done pulse, busy low
// PAUSE    | (step build) parked after GAP until step
module instr_issuer
    import instr_issuer_pkg::*;
#(
    parameter int          ADDR_W   = 4,
    parameter int unsigned START_PC = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [ADDR_W-1:0] prog_addr,
    input  logic [7:0]        prog_data,
    output logic [7:0]        word,
    output logic              reg_on,
    output logic [7:0]        in_val,
    output logic [1:0]        read_write,
    output logic [1:0]        rw_reg,
    input  logic [7:0]        rd_data,
    output logic              busy,
    output logic              done
`ifdef INSTR_ISSUER_STEP_EN
    ,
    input  logic              step
`endif
);

    localparam logic [ADDR_W-1:0] PC_START = ADDR_W'(START_PC);
    localparam logic [ADDR_W-1:0] PC_LAST  = {ADDR_W{1'b1}};

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] pc;
    logic [7:0]        instr;
    logic [7:0]        a_q;
    logic [7:0]        code_q;

    logic [3:0]        dec_op;
    logic [3:0]        instr_op;
    logic              pc_last;
    logic [7:0]        cmp_a;
    logic [7:0]        cmp_b;
    logic [7:0]        cmp_code;

    assign dec_op    = prog_data[7:4];
    assign instr_op  = instr[7:4];
    assign pc_last   = (pc == PC_LAST);
    assign prog_addr = pc;

    // CMI compares the first read against its immediate; CM compares stored A with the live second read.
    assign cmp_a = (state == S_RDA_W) ? rd_data : a_q;
    assign cmp_b = (state == S_RDA_W) ? cmi_imm(instr[1:0]) : rd_data;

    issuer_cmp u_cmp (
        .a    (cmp_a),
        .b    (cmp_b),
        .code (cmp_code)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (start) state_nxt = S_FETCH;
            S_FETCH:  state_nxt = S_WAIT;
            S_WAIT:   state_nxt = S_DECODE;
            S_DECODE: begin
                if (dec_op == OP_HALT) begin
                    state_nxt = S_DONE;
                end else if (is_cmp_op(dec_op)) begin
                    state_nxt = S_RDA;
                end else begin
                    state_nxt = S_ISSUE;
                end
            end
            S_ISSUE:  state_nxt = S_GAP;
`ifdef INSTR_ISSUER_STEP_EN
            S_GAP:    state_nxt = S_PAUSE;
            S_PAUSE:  if (step) state_nxt = pc_last ? S_DONE : S_FETCH;
`else
            S_GAP:    state_nxt = pc_last ? S_DONE : S_FETCH;
`endif
            S_RDA:    state_nxt = S_RDA_W;
            S_RDA_W:  state_nxt = (instr_op == OP_CM) ? S_RDB : S_ISSUE;
            S_RDB:    state_nxt = S_RDB_W;
            S_RDB_W:  state_nxt = S_ISSUE;
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Bus values are driven one cycle ahead of every strobe so they are stable across reg_on.
    always_comb begin
        word       = 8'h00;
        reg_on     = 1'b0;
        in_val     = 8'h00;
        read_write = RW_NONE;
        rw_reg     = 2'b00;
        busy       = (state != S_IDLE) && (state != S_DONE);
        done       = (state == S_DONE);
        case (state)
            S_DECODE: begin
                if (is_cmp_op(dec_op)) begin
                    word       = NOP_WORD;
                    read_write = RW_READ;
                    rw_reg     = prog_data[3:2];
                end else if (dec_op != OP_HALT) begin
                    word = prog_data;
                end
            end
            S_ISSUE: begin
                word   = instr;
                in_val = code_q;
                reg_on = 1'b1;
            end
            S_RDA: begin
                word       = NOP_WORD;
                read_write = RW_READ;
                rw_reg     = instr[3:2];
                reg_on     = 1'b1;
            end
            S_RDA_W: begin
                if (instr_op == OP_CM) begin
                    word       = NOP_WORD;
                    read_write = RW_READ;
                    rw_reg     = instr[1:0];
                end else begin
                    word   = instr;
                    in_val = cmp_code;
                end
            end
            S_RDB: begin
                word       = NOP_WORD;
                read_write = RW_READ;
                rw_reg     = instr[1:0];
                reg_on     = 1'b1;
            end
            S_RDB_W: begin
                word   = instr;
                in_val = cmp_code;
            end
            default: begin
                word = 8'h00;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc     <= PC_START;
            instr  <= 8'h00;
            a_q    <= 8'h00;
            code_q <= CMP_EQ;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) pc <= PC_START;
                end
                S_DECODE: begin
                    instr  <= prog_data;
                    code_q <= CMP_EQ;
                end
                S_RDA_W: begin
                    a_q <= rd_data;
                    if (instr_op == OP_CMI) code_q <= cmp_code;
                end
                S_RDB_W: begin
                    code_q <= cmp_code;
                end
                default: begin
                    code_q <= code_q;
                end
            endcase
            if ((state != S_IDLE) && (state_nxt == S_FETCH)) begin
                pc <= pc + ADDR_W'(1);
            end
        end
    end

endmodule
